// File: rtl/rf_pkg.sv
// Shared defaults and option constants for the scoreboarded register file.
package rf_pkg;

  localparam int unsigned RF_DATA_W   = 16;
  localparam int unsigned RF_ADDR_W   = 3;

  // Option constants: register 0 hardwired to zero, same-cycle write forwarding.
  localparam bit          RF_ZERO_REG = 1'b0;
  localparam bit          RF_BYPASS   = 1'b1;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking: issue marks a destination busy, writeback clears it.
// Also produces the read-port hazard terms and the sticky double-issue error.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter bit          ZERO_REG = RF_ZERO_REG,
  parameter bit          BYPASS   = RF_BYPASS,
  localparam int unsigned DEPTH   = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              hazard1,
  output logic              hazard2,
  output logic [DEPTH-1:0]  busy_vec,
  output logic              sb_err
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             sb_err_q;
  logic             sb_err_d;
  logic             issue_live;

  // Next busy/error state; issue is applied after write so a same-cycle issue wins.
  always_comb begin
    busy_d     = busy_q;
    issue_live = issue_en && !(ZERO_REG && issue_addr == '0);
    if (wr_en) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (issue_live) begin
      busy_d[issue_addr] = 1'b1;
    end
    sb_err_d = sb_err_q ||
               (issue_live && busy_q[issue_addr] && !(wr_en && wr_addr == issue_addr));
  end

  // Busy bits and sticky error register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
    end
  end

  // A pending producer is a hazard unless its result is being forwarded this cycle.
  always_comb begin
    hazard1 = busy_q[rd_addr1] && !(BYPASS && wr_en && wr_addr == rd_addr1) &&
              !(ZERO_REG && rd_addr1 == '0);
    hazard2 = busy_q[rd_addr2] && !(BYPASS && wr_en && wr_addr == rd_addr2) &&
              !(ZERO_REG && rd_addr2 == '0);
  end

  assign busy_vec = busy_q;
  assign sb_err   = sb_err_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port, optional
// write-to-read bypass and hardwired zero register, plus a busy scoreboard.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter bit          ZERO_REG = RF_ZERO_REG,
  parameter bit          BYPASS   = RF_BYPASS,
  localparam int unsigned DEPTH   = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              hazard1,
  output logic              hazard2,
  output logic [DEPTH-1:0]  busy_vec,
  output logic              sb_err
);

  logic [DATA_W-1:0] regs [DEPTH];

  // Storage array; writes to r0 are dropped when it is hardwired to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && !(ZERO_REG && wr_addr == '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read muxing: array, then bypass, then forced zero (r0 or reset held, so a
  // forwarded write cannot leak out while the array is being cleared).
  always_comb begin
    rd_data1 = regs[rd_addr1];
    rd_data2 = regs[rd_addr2];
    if (BYPASS && wr_en && wr_addr == rd_addr1) begin
      rd_data1 = wr_data;
    end
    if (BYPASS && wr_en && wr_addr == rd_addr2) begin
      rd_data2 = wr_data;
    end
    if (!rst_n || (ZERO_REG && rd_addr1 == '0)) begin
      rd_data1 = '0;
    end
    if (!rst_n || (ZERO_REG && rd_addr2 == '0)) begin
      rd_data2 = '0;
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .hazard1    (hazard1),
    .hazard2    (hazard2),
    .busy_vec   (busy_vec),
    .sb_err     (sb_err)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: dut_a uses ZERO_REG=0/BYPASS=1, dut_b uses
// ZERO_REG=1/BYPASS=0. Both see the same stimulus; expectations are queued by
// the stimulus and compared by a monitor on the falling clock edge.
module tb_reg_file_sb;

  localparam int F_RD1  = 0;
  localparam int F_RD2  = 1;
  localparam int F_HZ1  = 2;
  localparam int F_HZ2  = 3;
  localparam int F_BUSY = 4;
  localparam int F_ERR  = 5;

  typedef struct {
    string       name;
    bit          sel_b;
    int          field;
    logic [31:0] value;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [2:0]  rd_addr1, rd_addr2, wr_addr, issue_addr;
  logic        wr_en, issue_en;
  logic [15:0] wr_data;

  logic [15:0] rd_data1_a, rd_data2_a, rd_data1_b, rd_data2_b;
  logic        hazard1_a, hazard2_a, hazard1_b, hazard2_b;
  logic [7:0]  busy_vec_a, busy_vec_b;
  logic        sb_err_a, sb_err_b;

  exp_t sb_q[$];
  exp_t cur;
  int   vectors;
  int   miscompares;

  reg_file_sb #(
    .DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1_a), .rd_data2(rd_data2_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .hazard1(hazard1_a), .hazard2(hazard2_a),
    .busy_vec(busy_vec_a), .sb_err(sb_err_a)
  );

  reg_file_sb #(
    .DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1_b), .rd_data2(rd_data2_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .hazard1(hazard1_b), .hazard2(hazard2_b),
    .busy_vec(busy_vec_b), .sb_err(sb_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] actual(input bit sel_b, input int field);
    logic [31:0] v;
    v = '0;
    case (field)
      F_RD1:  v = sel_b ? 32'(rd_data1_b) : 32'(rd_data1_a);
      F_RD2:  v = sel_b ? 32'(rd_data2_b) : 32'(rd_data2_a);
      F_HZ1:  v = sel_b ? 32'(hazard1_b)  : 32'(hazard1_a);
      F_HZ2:  v = sel_b ? 32'(hazard2_b)  : 32'(hazard2_a);
      F_BUSY: v = sel_b ? 32'(busy_vec_b) : 32'(busy_vec_a);
      F_ERR:  v = sel_b ? 32'(sb_err_b)   : 32'(sb_err_a);
      default: v = 32'hDEAD_DEAD;
    endcase
    return v;
  endfunction

  // Monitor: drain all queued expectations against the outputs at mid-cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      vectors++;
      if (actual(cur.sel_b, cur.field) !== cur.value) begin
        miscompares++;
        $display("FAIL %s (%s): got %h expected %h", cur.name,
                 cur.sel_b ? "dut_b" : "dut_a", actual(cur.sel_b, cur.field), cur.value);
      end
    end
  end

  task automatic exp2(input string nm, input int field,
                      input logic [31:0] va, input logic [31:0] vb);
    exp_t e;
    e.name = nm; e.field = field;
    e.sel_b = 1'b0; e.value = va; sb_q.push_back(e);
    e.sel_b = 1'b1; e.value = vb; sb_q.push_back(e);
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic ie, input logic [2:0] ia,
                       input logic [2:0] ra1, input logic [2:0] ra2);
    wr_en = we; wr_addr = wa; wr_data = wd;
    issue_en = ie; issue_addr = ia;
    rd_addr1 = ra1; rd_addr2 = ra2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
    next_cycle();

    // In reset: a write aimed at the read address must not show through.
    drive(1'b1, 3'd3, 16'hBEEF, 1'b1, 3'd3, 3'd3, 3'd3);
    exp2("rst_rd1", F_RD1, 32'h0, 32'h0);
    exp2("rst_busy", F_BUSY, 32'h0, 32'h0);
    exp2("rst_err", F_ERR, 32'h0, 32'h0);
    next_cycle();

    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'(a), 3'(7 - a));
      exp2("init_rd1", F_RD1, 32'h0, 32'h0);
      exp2("init_rd2", F_RD2, 32'h0, 32'h0);
      exp2("init_hz1", F_HZ1, 32'h0, 32'h0);
      next_cycle();
    end
    exp2("init_busy", F_BUSY, 32'h0, 32'h0);
    exp2("init_err", F_ERR, 32'h0, 32'h0);

    // r3 = BEEF: forwarded same cycle on both ports only with bypass.
    drive(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 3'd3, 3'd3);
    exp2("w3_rd1_same", F_RD1, 32'hBEEF, 32'h0);
    exp2("w3_rd2_same", F_RD2, 32'hBEEF, 32'h0);
    next_cycle();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd3, 3'd3);
    exp2("w3_rd1_next", F_RD1, 32'hBEEF, 32'hBEEF);
    next_cycle();

    // Issue r5: nothing visible until after the edge.
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 3'd5, 3'd0);
    exp2("i5_hz1_same", F_HZ1, 32'h0, 32'h0);
    exp2("i5_busy_same", F_BUSY, 32'h0, 32'h0);
    next_cycle();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd5, 3'd0);
    exp2("i5_hz1", F_HZ1, 32'h1, 32'h1);
    exp2("i5_busy", F_BUSY, 32'h20, 32'h20);
    next_cycle();
    drive(1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 3'd5, 3'd0);
    exp2("w5_hz1_same", F_HZ1, 32'h0, 32'h1);
    exp2("w5_rd1_same", F_RD1, 32'h1234, 32'h0);
    exp2("w5_busy_same", F_BUSY, 32'h20, 32'h20);
    next_cycle();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd5, 3'd0);
    exp2("w5_busy", F_BUSY, 32'h0, 32'h0);
    exp2("w5_rd1", F_RD1, 32'h1234, 32'h1234);
    exp2("w5_hz1", F_HZ1, 32'h0, 32'h0);
    next_cycle();

    // r0: real register in dut_a, hardwired zero in dut_b.
    drive(1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 3'd0, 3'd0);
    exp2("z_rd1_same", F_RD1, 32'hFFFF, 32'h0);
    exp2("z_rd2_same", F_RD2, 32'hFFFF, 32'h0);
    exp2("z_hz1_same", F_HZ1, 32'h0, 32'h0);
    next_cycle();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
    exp2("z_rd1", F_RD1, 32'hFFFF, 32'h0);
    exp2("z_hz1", F_HZ1, 32'h1, 32'h0);
    exp2("z_busy", F_BUSY, 32'h01, 32'h00);
    exp2("z_err", F_ERR, 32'h0, 32'h0);
    next_cycle();
    drive(1'b1, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0);
    exp2("z_clr_hz1", F_HZ1, 32'h0, 32'h0);
    exp2("z_clr_rd1", F_RD1, 32'h0, 32'h0);
    next_cycle();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
    exp2("z_clr_busy", F_BUSY, 32'h0, 32'h0);
    next_cycle();

    // Issue and write r2 together: data lands, busy stays set, no error.
    drive(1'b1, 3'd2, 16'h00AA, 1'b1, 3'd2, 3'd0, 3'd2);
    exp2("iw2_rd2_same", F_RD2, 32'h00AA, 32'h0);
    exp2("iw2_hz2_same", F_HZ2, 32'h0, 32'h0);
    next_cycle();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd2);
    exp2("iw2_rd2", F_RD2, 32'h00AA, 32'h00AA);
    exp2("iw2_hz2", F_HZ2, 32'h1, 32'h1);
    exp2("iw2_busy", F_BUSY, 32'h04, 32'h04);
    exp2("iw2_err", F_ERR, 32'h0, 32'h0);
    next_cycle();
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd0, 3'd2);
    exp2("dbl_err_same", F_ERR, 32'h0, 32'h0);
    next_cycle();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd2);
    exp2("dbl_err", F_ERR, 32'h1, 32'h1);
    exp2("dbl_busy", F_BUSY, 32'h04, 32'h04);
    next_cycle();
    exp2("dbl_err_sticky", F_ERR, 32'h1, 32'h1);
    next_cycle();

    // r1 = 5555 and busy, giving busy_vec = 06 before the mid-run reset.
    drive(1'b1, 3'd1, 16'h5555, 1'b1, 3'd1, 3'd1, 3'd2);
    exp2("w1_rd1_same", F_RD1, 32'h5555, 32'h0);
    next_cycle();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd1, 3'd2);
    exp2("pre_rst_rd1", F_RD1, 32'h5555, 32'h5555);
    exp2("pre_rst_busy", F_BUSY, 32'h06, 32'h06);
    exp2("pre_rst_hz1", F_HZ1, 32'h1, 32'h1);
    exp2("pre_rst_err", F_ERR, 32'h1, 32'h1);
    next_cycle();

    // Asynchronous reset: checked before any rising edge occurs.
    rst_n = 1'b0;
    exp2("arst_rd1", F_RD1, 32'h0, 32'h0);
    exp2("arst_rd2", F_RD2, 32'h0, 32'h0);
    exp2("arst_hz1", F_HZ1, 32'h0, 32'h0);
    exp2("arst_hz2", F_HZ2, 32'h0, 32'h0);
    exp2("arst_busy", F_BUSY, 32'h0, 32'h0);
    exp2("arst_err", F_ERR, 32'h0, 32'h0);
    next_cycle();

    // First edge after release may write.
    rst_n = 1'b1;
    drive(1'b1, 3'd6, 16'h6666, 1'b0, 3'd0, 3'd6, 3'd1);
    exp2("post_rst_rd1_same", F_RD1, 32'h6666, 32'h0);
    exp2("post_rst_rd2", F_RD2, 32'h0, 32'h0);
    next_cycle();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd6, 3'd1);
    exp2("post_rst_rd1", F_RD1, 32'h6666, 32'h6666);
    exp2("post_rst_busy", F_BUSY, 32'h0, 32'h0);
    next_cycle();

    // Bounded drain of anything still queued.
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) begin
      @(negedge clk);
    end
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
